// File: rtl/rx_frame_pkg.sv
// Shared types for the UART frame controller: FSM states,
// drop reason codes and the default start-of-frame marker.
package rx_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CHK     = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ERR_TIMEOUT = 2'd0,
        ERR_LEN     = 2'd1,
        ERR_SPACE   = 2'd2,
        ERR_CHK     = 2'd3
    } err_t;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/rx_frame_fifo.sv
// Payload FIFO with a speculative write pointer that is either
// committed or rewound per frame; the read side only sees commits.
module rx_frame_fifo #(
    parameter  int W     = 9,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          commit,
    input  logic          rewind,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic          rd_valid,
    output logic [AW:0]   free
);

    localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q, wr_d;
    logic [AW:0]  cm_q, cm_d;
    logic [AW:0]  rd_q, rd_d;
    logic         pop;

    assign rd_valid = (cm_q != rd_q);
    assign pop      = rd_en && rd_valid;
    assign rd_data  = rd_valid ? mem_q[rd_q[AW-1:0]] : '0;

    // A same-cycle pop already frees its slot for the LEN check.
    assign free = DEPTH_P - (wr_q - rd_q)
                + {{AW{1'b0}}, pop};

    always_comb begin
        wr_d = wr_q + {{AW{1'b0}}, wr_en};
        cm_d = cm_q;
        rd_d = rd_q + {{AW{1'b0}}, pop};
        if (rewind) begin
            wr_d = cm_q;
        end
        if (commit) begin
            cm_d = wr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_q[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            cm_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            cm_q <= cm_d;
            rd_q <= rd_d;
        end
    end

endmodule

// File: rtl/rx_frame_ctrl.sv
// Parses SOF/LEN/payload/CHK frames from the UART receiver and
// releases payload downstream only once the checksum matches.
module rx_frame_ctrl
    import rx_frame_pkg::*;
#(
    parameter int              SIZE    = 8,
    parameter int              DEPTH   = 16,
    parameter logic [SIZE-1:0] SOF     = SIZE'(SOF_DEFAULT),
    parameter int              TIMEOUT = 20000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rx_done,
    input  logic [SIZE-1:0] data_in,
    output logic [SIZE-1:0] pkt_data,
    output logic            pkt_last,
    output logic            pkt_valid,
    input  logic            pkt_ready,
    output logic            frame_ok,
    output logic            frame_err,
    output logic [1:0]      err_code
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT);

    state_t          state_q, state_d;
    logic [SIZE-1:0] len_q, len_d;
    logic [SIZE-1:0] cnt_q, cnt_d;
    logic [SIZE-1:0] chk_q, chk_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            ok_q, ok_d;
    logic            err_q, err_d;
    err_t            code_q, code_d;

    logic            wr_en;
    logic            wr_last;
    logic            commit;
    logic            rewind;
    logic [SIZE:0]   rd_word;
    logic [AW:0]     free;
    logic            tmo_hit;

    assign tmo_hit = (state_q != ST_IDLE) && !rx_done
                  && (tmo_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        chk_d   = chk_q;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
        wr_en   = 1'b0;
        wr_last = 1'b0;
        commit  = 1'b0;
        rewind  = 1'b0;
        if (rx_done) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (data_in == SOF) begin
                        state_d = ST_LEN;
                    end
                end
                ST_LEN: begin
                    len_d = data_in;
                    chk_d = data_in;
                    cnt_d = '0;
                    if (data_in == '0) begin
                        err_d   = 1'b1;
                        code_d  = ERR_LEN;
                        state_d = ST_IDLE;
                    end else if (32'(data_in) > 32'(free)) begin
                        err_d   = 1'b1;
                        code_d  = ERR_SPACE;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    wr_en   = 1'b1;
                    wr_last = (cnt_q == len_q - SIZE'(1));
                    chk_d   = chk_q ^ data_in;
                    cnt_d   = cnt_q + SIZE'(1);
                    if (wr_last) begin
                        state_d = ST_CHK;
                    end
                end
                ST_CHK: begin
                    state_d = ST_IDLE;
                    if (data_in == chk_q) begin
                        commit = 1'b1;
                        ok_d   = 1'b1;
                    end else begin
                        rewind = 1'b1;
                        err_d  = 1'b1;
                        code_d = ERR_CHK;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (tmo_hit) begin
            rewind  = 1'b1;
            err_d   = 1'b1;
            code_d  = ERR_TIMEOUT;
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        tmo_d = tmo_q + TW'(1);
        if ((state_q == ST_IDLE) || rx_done || tmo_hit) begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            chk_q   <= '0;
            tmo_q   <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_TIMEOUT;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            chk_q   <= chk_d;
            tmo_q   <= tmo_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    rx_frame_fifo #(
        .W     (SIZE + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  ({wr_last, data_in}),
        .commit   (commit),
        .rewind   (rewind),
        .rd_en    (pkt_ready),
        .rd_data  (rd_word),
        .rd_valid (pkt_valid),
        .free     (free)
    );

    assign pkt_data  = rd_word[SIZE-1:0];
    assign pkt_last  = rd_word[SIZE];
    assign frame_ok  = ok_q;
    assign frame_err = err_q;
    assign err_code  = code_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Directed and randomized frame traffic for rx_frame_ctrl, checked
// against a byte-level model of the frame rules.
module tb_rx_frame_ctrl;

    localparam int DEPTH = 16;
    localparam int TMO   = 64;

    typedef logic [7:0] bq_t [$];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_done = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       pkt_ready = 1'b0;
    logic [7:0] pkt_data;
    logic       pkt_last;
    logic       pkt_valid;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;

    rx_frame_ctrl #(
        .SIZE    (8),
        .DEPTH   (DEPTH),
        .SOF     (8'hA5),
        .TIMEOUT (TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_done   (rx_done),
        .data_in   (data_in),
        .pkt_data  (pkt_data),
        .pkt_last  (pkt_last),
        .pkt_valid (pkt_valid),
        .pkt_ready (pkt_ready),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int ok_cnt = 0;
    int err_cnt = 0;
    int sync_bad = 0;
    int exp_ok = 0;
    int exp_err = 0;
    int backlog = 0;
    logic [1:0] exp_code = 2'd0;
    logic [8:0] exp_q [$];
    logic [8:0] got_q [$];

    // Observe delivered beats and status pulses mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pkt_valid && pkt_ready)
                got_q.push_back({pkt_last, pkt_data});
            if (frame_ok) begin
                ok_cnt++;
                if (!pkt_valid) sync_bad++;
            end
            if (frame_err) err_cnt++;
        end
    end

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [7:0] b);
        rx_done = 1'b1;
        data_in = b;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
    endtask

    function automatic bq_t mk_frame(input int len, input bit bad);
        bq_t f;
        logic [7:0] x;
        logic [7:0] b;
        f.push_back(8'hA5);
        f.push_back(8'(len));
        x = 8'(len);
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            f.push_back(b);
            x ^= b;
        end
        if (bad) x ^= 8'($urandom_range(1, 255));
        f.push_back(x);
        return f;
    endfunction

    task automatic drain_check(input string tag);
        int n;
        pkt_ready = 1'b1;
        for (int i = 0; i < 200 && got_q.size() < exp_q.size(); i++)
            tick(1);
        tick(2);
        check({tag, "_beats"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check({tag, "_beat"}, {23'd0, got_q[i]}, {23'd0, exp_q[i]});
        check({tag, "_empty"}, pkt_valid, 1'b0);
        exp_q.delete();
        got_q.delete();
        backlog = 0;
    endtask

    task automatic send_frame(input bq_t f, input bit drain,
                              input string tag);
        int len;
        int n_send;
        logic [7:0] x;
        len = f[1];
        if (len == 0) begin
            exp_err++;
            exp_code = 2'd1;
            n_send = 2;
        end else if (len > DEPTH - backlog) begin
            exp_err++;
            exp_code = 2'd2;
            n_send = 2;
        end else begin
            n_send = len + 3;
            x = f[1];
            for (int i = 0; i < len; i++) x ^= f[2 + i];
            if (f[len + 2] == x) begin
                exp_ok++;
                backlog += len;
                for (int i = 0; i < len; i++)
                    exp_q.push_back({i == len - 1, f[2 + i]});
            end else begin
                exp_err++;
                exp_code = 2'd3;
            end
        end
        for (int i = 0; i < n_send; i++) drive(f[i]);
        tick(3);
        check({tag, "_okcnt"}, ok_cnt, exp_ok);
        check({tag, "_errcnt"}, err_cnt, exp_err);
        check({tag, "_code"}, err_code, exp_code);
        if (drain) drain_check(tag);
    endtask

    initial begin
        bq_t good;
        bq_t f10;
        good = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};

        tick(3);
        check("rst_valid", pkt_valid, 1'b0);
        check("rst_data", pkt_data, 8'h00);
        check("rst_last", pkt_last, 1'b0);
        check("rst_ok", frame_ok, 1'b0);
        check("rst_err", frame_err, 1'b0);
        check("rst_code", err_code, 2'd0);
        rst_n = 1'b1;
        tick(2);

        pkt_ready = 1'b1;
        send_frame(good, 1'b1, "good");
        send_frame('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00},
                   1'b1, "chkfail");
        send_frame(mk_frame(16, 1'b0), 1'b1, "full16");

        drive(8'h00);
        drive(8'hFF);
        drive(8'h5A);
        send_frame(good, 1'b1, "garbage");

        drive(8'hA5);
        drive(8'h02);
        drive(8'h11);
        tick(TMO - 2);
        check("tmo_early", err_cnt, exp_err);
        tick(4);
        exp_err++;
        exp_code = 2'd0;
        check("tmo_err", err_cnt, exp_err);
        check("tmo_code", err_code, 2'd0);
        check("tmo_nodata", got_q.size(), 0);
        send_frame(good, 1'b1, "post_tmo");

        pkt_ready = 1'b0;
        f10 = mk_frame(10, 1'b0);
        send_frame(f10, 1'b0, "space_a");
        send_frame(mk_frame(10, 1'b0), 1'b0, "space_b");
        send_frame('{8'hA5, 8'h00}, 1'b0, "len0");
        check("space_noout", got_q.size(), 0);
        drain_check("space_pop");
        pkt_ready = 1'b0;
        send_frame(f10, 1'b0, "space_c");
        send_frame(mk_frame(7, 1'b0), 1'b0, "space_7");
        drain_check("space_c_pop");
        send_frame(mk_frame(17, 1'b0), 1'b1, "len17");

        for (int k = 0; k < 24; k++) begin
            pkt_ready = 1'b1;
            send_frame(mk_frame($urandom_range(0, 18),
                                $urandom_range(0, 3) == 0),
                       1'b1, "rnd");
        end

        pkt_ready = 1'b0;
        send_frame(good, 1'b0, "pre_rst");
        send_frame(mk_frame(2, 1'b1), 1'b0, "pre_rst_bad");
        drive(8'hA5);
        drive(8'h03);
        drive(8'h11);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        backlog = 0;
        exp_code = 2'd0;
        check("mid_valid", pkt_valid, 1'b0);
        check("mid_data", pkt_data, 8'h00);
        check("mid_last", pkt_last, 1'b0);
        check("mid_ok", frame_ok, 1'b0);
        check("mid_err", frame_err, 1'b0);
        check("mid_code", err_code, 2'd0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        pkt_ready = 1'b1;
        tick(2);
        check("mid_stay_empty", got_q.size(), 0);
        send_frame(good, 1'b1, "post_rst");

        check("ok_valid_sync", sync_bad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
